// File: rtl/axi4_lite_slave_write_ctrl.sv
`timescale 1ns/1ps
// axi4_lite_slave_write_ctrl
//
// Slave-side AXI4-Lite write responder. It accepts one AW beat and one W beat
// in either order, commits them to a word-indexed memory through a
// single-cycle write port, and then holds the B response until the master
// takes it. Only one transaction is in flight at a time.
//
// Ports:
//   ACLK, ARESET                 clock (rising edge), async active-high reset
//   AWADDR/AWVALID/AWREADY       write address channel (AWADDR is a word index)
//   WDATA/WSTRB/WVALID/WREADY    write data channel
//   BRESP/BVALID/BREADY          write response channel (00 OKAY, 10 SLVERR)
//   mem_we/mem_addr/mem_wdata/mem_wstrb
//                                single-cycle write port into the storage array
//   dbg_state_o                  current FSM state, for observation only
//
// Handshake semantics: a transfer happens on a rising ACLK edge where VALID
// and READY are both 1. READY never depends combinationally on VALID; a
// VALID seen while READY is 0 is ignored, so the master must keep holding it.
// Once BVALID rises, BVALID and BRESP stay fixed until the edge where BREADY
// is also 1.
module axi4_lite_slave_write_ctrl #(
  parameter int Addr_Width = 32,
  parameter int Data_Width = 32,
  parameter int MEM_DEPTH  = 4096
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic [Addr_Width-1:0]   AWADDR,
  input  logic                    AWVALID,
  output logic                    AWREADY,
  input  logic [Data_Width-1:0]   WDATA,
  input  logic [Data_Width/8-1:0] WSTRB,
  input  logic                    WVALID,
  output logic                    WREADY,
  output logic [1:0]              BRESP,
  output logic                    BVALID,
  input  logic                    BREADY,
  output logic                    mem_we,
  output logic [Addr_Width-1:0]   mem_addr,
  output logic [Data_Width-1:0]   mem_wdata,
  output logic [Data_Width/8-1:0] mem_wstrb,
  output logic [2:0]              dbg_state_o
);

  localparam int STRB_W = Data_Width / 8;
  localparam logic [Addr_Width-1:0] DEPTH_L = Addr_Width'(MEM_DEPTH);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    HAVE_ADDR = 3'd1,
    HAVE_DATA = 3'd2,
    WRITE     = 3'd3,
    RESP      = 3'd4
  } state_e;

  state_e state_q, state_d;

  logic              awready_q, awready_d;
  logic              wready_q, wready_d;
  logic              bvalid_q, bvalid_d;
  logic [1:0]        bresp_q, bresp_d;
  logic [Addr_Width-1:0] addr_q;
  logic [Data_Width-1:0] data_q;
  logic [STRB_W-1:0]     strb_q;

  logic aw_hs;
  logic w_hs;
  logic addr_ok;

  // READY outputs are registers, so the handshake is simply VALID & READY.
  assign aw_hs   = AWVALID & awready_q;
  assign w_hs    = WVALID & wready_q;
  // Full-width unsigned compare: no aliasing of high address bits.
  assign addr_ok = (addr_q < DEPTH_L);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (aw_hs && w_hs) state_d = WRITE;
        else if (aw_hs)    state_d = HAVE_ADDR;
        else if (w_hs)     state_d = HAVE_DATA;
      end
      HAVE_ADDR: if (w_hs)  state_d = WRITE;
      HAVE_DATA: if (aw_hs) state_d = WRITE;
      WRITE:     state_d = RESP;
      RESP:      if (bvalid_q && BREADY) state_d = IDLE;
      default:   state_d = IDLE;
    endcase

    // Channel outputs are decoded from where the FSM is going, so they are
    // registered yet already correct in the first cycle of each state.
    awready_d = (state_d == IDLE) || (state_d == HAVE_DATA);
    wready_d  = (state_d == IDLE) || (state_d == HAVE_ADDR);
    bvalid_d  = (state_d == RESP);

    // The response is decided once, on leaving WRITE, and then held for the
    // whole RESP stay so BREADY toggling cannot disturb it.
    bresp_d = RESP_OKAY;
    if (state_d == RESP) begin
      if (state_q == WRITE) bresp_d = addr_ok ? RESP_OKAY : RESP_SLVERR;
      else                  bresp_d = bresp_q;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q   <= IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      state_q   <= state_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      addr_q <= '0;
      data_q <= '0;
      strb_q <= '0;
    end else begin
      if (aw_hs) addr_q <= AWADDR;
      if (w_hs) begin
        data_q <= WDATA;
        strb_q <= WSTRB;
      end
    end
  end

  assign AWREADY = awready_q;
  assign WREADY  = wready_q;
  assign BVALID  = bvalid_q;
  assign BRESP   = bresp_q;

  // Memory port is live only during WRITE with an in-range address; the
  // data lines are zeroed otherwise so the array sees a quiet bus.
  assign mem_we    = (state_q == WRITE) && addr_ok;
  assign mem_addr  = mem_we ? addr_q : '0;
  assign mem_wdata = mem_we ? data_q : '0;
  assign mem_wstrb = mem_we ? strb_q : '0;

  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_axi4_lite_slave_write_ctrl.sv
`timescale 1ns/1ps
// Testbench for axi4_lite_slave_write_ctrl: directed vector table, hand-coded
// multi-cycle sequences (reset, ignored VALID, minimum period) and a random
// phase checked against a rule-level model of the write path.
module tb_axi4_lite_slave_write_ctrl;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int DEPTH = 4096;

  logic          ACLK = 1'b0;
  logic          ARESET;
  logic [AW-1:0] AWADDR;
  logic          AWVALID;
  logic          AWREADY;
  logic [DW-1:0] WDATA;
  logic [SW-1:0] WSTRB;
  logic          WVALID;
  logic          WREADY;
  logic [1:0]    BRESP;
  logic          BVALID;
  logic          BREADY;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [SW-1:0] mem_wstrb;
  logic [2:0]    dbg_state;

  axi4_lite_slave_write_ctrl #(
    .Addr_Width(AW), .Data_Width(DW), .MEM_DEPTH(DEPTH)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 ACLK = ~ACLK;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_hs = 0;
  bit released = 1'b0;

  always @(posedge ACLK) cyc <= cyc + 1;

  // Expected memory writes: {addr, data, strb}
  logic [AW+DW+SW-1:0] exp_q[$];

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  // ---------------- scoreboard / protocol monitor ----------------
  bit         hold_pend = 1'b0;
  logic [1:0] held_resp = 2'b00;

  always @(negedge ACLK) begin
    if (mem_we) begin
      if (exp_q.size() == 0) check("unexpected_mem_we", 1, 0);
      else check("mem_write", {mem_addr, mem_wdata, mem_wstrb}, exp_q.pop_front());
    end
    if (ARESET) begin
      check("bvalid_in_reset", BVALID, 0);
    end else if (released) begin
      check("no_x_outputs", $isunknown({AWREADY, WREADY, BVALID, BRESP, mem_we, dbg_state}), 0);
      if (hold_pend) check("b_stable_until_bready", {BVALID, BRESP}, {1'b1, held_resp});
    end
    hold_pend = !ARESET && BVALID && !BREADY;
    held_resp = BRESP;
  end

  // ---------------- driver ----------------
  task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                          input logic [SW-1:0] strb, input int aw_dly, input int w_dly,
                          input int b_dly, input logic exp_we, input logic [1:0] exp_resp);
    if (exp_we) exp_q.push_back({addr, data, strb});
    BREADY = (b_dly == 0);
    fork
      begin
        bit done;
        done = 1'b0;
        repeat (aw_dly) tick();
        AWADDR = addr;
        AWVALID = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
          if (AWREADY) done = 1'b1;
          tick();
        end
        AWVALID = 1'b0;
        AWADDR = ~addr;
        check("aw_handshake", done, 1);
        check("awready_drop", AWREADY, 0);
      end
      begin
        bit done;
        done = 1'b0;
        repeat (w_dly) tick();
        WDATA = data;
        WSTRB = strb;
        WVALID = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
          if (WREADY) done = 1'b1;
          tick();
        end
        WVALID = 1'b0;
        WDATA = ~data;
        WSTRB = ~strb;
        check("w_handshake", done, 1);
        check("wready_drop", WREADY, 0);
      end
    join
    last_hs = cyc;
    check("mem_we_latency", mem_we, exp_we);
    check("bvalid_not_early", BVALID, 0);
    tick();
    check("bvalid_rise", BVALID, 1);
    check("bresp", BRESP, exp_resp);
    check("mem_we_one_cycle", mem_we, 0);
    for (int i = 0; i < b_dly; i++) begin
      tick();
      check("bvalid_backpressure", BVALID, 1);
      check("bresp_backpressure", BRESP, exp_resp);
      check("ready_low_in_resp", {AWREADY, WREADY}, 2'b00);
    end
    BREADY = 1'b1;
    tick();
    check("bvalid_clear", BVALID, 0);
    check("ready_return", {AWREADY, WREADY}, 2'b11);
    BREADY = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
    int            aw_dly;
    int            w_dly;
    int            b_dly;
    logic          exp_we;
    logic [1:0]    exp_resp;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int prev_hs;
    vecs[0] = '{32'h0000_0a9b, 32'h1a2b3c4d, 4'hf, 0, 0, 0, 1'b1, 2'b00}; // simultaneous
    vecs[1] = '{32'h0000_0010, 32'hdeadbeef, 4'h3, 3, 0, 0, 1'b1, 2'b00}; // W before AW
    vecs[2] = '{32'h0000_1000, 32'h11223344, 4'hf, 0, 0, 0, 1'b0, 2'b10}; // first bad addr
    vecs[3] = '{32'h0000_0fff, 32'hcafef00d, 4'hf, 0, 0, 5, 1'b1, 2'b00}; // last good + backpressure
    vecs[4] = '{32'h0000_0040, 32'h55aa55aa, 4'h0, 0, 2, 1, 1'b1, 2'b00}; // AW first, zero strobe
    vecs[5] = '{32'hffff_ffff, 32'h00000000, 4'h1, 1, 1, 2, 1'b0, 2'b10}; // top of address space
    vecs[6] = '{32'h0001_0005, 32'h87654321, 4'hc, 0, 0, 1, 1'b0, 2'b10}; // would alias if truncated
    vecs[7] = '{32'h0000_0000, 32'h0f0f0f0f, 4'h8, 1, 0, 0, 1'b1, 2'b00}; // address zero

    ARESET = 1'b1;
    AWADDR = '0; AWVALID = 1'b0;
    WDATA = '0; WSTRB = '0; WVALID = 1'b0;
    BREADY = 1'b0;
    #1;
    check("reset_async_outputs",
          {AWREADY, WREADY, BVALID, BRESP, mem_we, mem_wstrb}, '0);
    check("reset_mem_bus", {mem_addr, mem_wdata}, '0);
    tick();
    tick();
    check("reset_held_ready", {AWREADY, WREADY}, 2'b00);
    ARESET = 1'b0;
    released = 1'b1;
    tick();
    check("first_edge_ready", {AWREADY, WREADY, BVALID}, 3'b110);

    // Directed table
    for (int v = 0; v < 8; v++) begin
      do_write(vecs[v].addr, vecs[v].data, vecs[v].strb, vecs[v].aw_dly, vecs[v].w_dly,
               vecs[v].b_dly, vecs[v].exp_we, vecs[v].exp_resp);
    end

    // Minimum period: back-to-back with BREADY held high -> 3 cycles apart
    do_write(32'h100, 32'h01020304, 4'hf, 0, 0, 0, 1'b1, 2'b00);
    prev_hs = last_hs;
    do_write(32'h101, 32'h05060708, 4'hf, 0, 0, 0, 1'b1, 2'b00);
    check("min_period", 32'(last_hs - prev_hs), 3);

    // W held while WREADY=0 is ignored; the first captured beat is written
    exp_q.push_back({32'h60, 32'h11111111, 4'hf});
    WDATA = 32'h11111111; WSTRB = 4'hf; WVALID = 1'b1;
    tick();
    WDATA = 32'h22222222; WSTRB = 4'h1;
    tick();
    tick();
    check("w_ignored_state_ready", {AWREADY, WREADY}, 2'b10);
    WVALID = 1'b0;
    AWADDR = 32'h60; AWVALID = 1'b1;
    tick();
    AWVALID = 1'b0;
    check("late_aw_mem_we", mem_we, 1);
    BREADY = 1'b1;
    tick();
    check("late_aw_bvalid", {BVALID, BRESP}, 3'b100);
    tick();
    check("late_aw_bdone", BVALID, 0);
    BREADY = 1'b0;

    // Reset while BVALID is high
    exp_q.push_back({32'h30, 32'h0badf00d, 4'hf});
    AWADDR = 32'h30; AWVALID = 1'b1;
    WDATA = 32'h0badf00d; WSTRB = 4'hf; WVALID = 1'b1;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0;
    check("rst_pre_mem_we", mem_we, 1);
    tick();
    check("rst_pre_bvalid", BVALID, 1);
    #2 ARESET = 1'b1;
    #1;
    check("rst_mid_resp_async", {BVALID, AWREADY, WREADY, BRESP}, '0);
    tick();
    tick();
    check("rst_no_mem_we", mem_we, 0);
    ARESET = 1'b0;
    tick();
    check("rst_release_ready", {AWREADY, WREADY}, 2'b11);
    do_write(32'h20, 32'ha5a5a5a5, 4'hf, 0, 0, 0, 1'b1, 2'b00);

    // Reset with a captured address pending: the address must be discarded
    AWADDR = 32'h50; AWVALID = 1'b1;
    tick();
    AWVALID = 1'b0;
    check("have_addr_ready", {AWREADY, WREADY}, 2'b01);
    #2 ARESET = 1'b1;
    #1;
    check("rst_have_addr_async", {AWREADY, WREADY}, 2'b00);
    tick();
    ARESET = 1'b0;
    tick();
    WDATA = 32'h77777777; WSTRB = 4'h6; WVALID = 1'b1;
    tick();
    WVALID = 1'b0;
    check("pending_addr_dropped", {mem_we, AWREADY, WREADY}, 3'b010);
    exp_q.push_back({32'h58, 32'h77777777, 4'h6});
    AWADDR = 32'h58; AWVALID = 1'b1;
    tick();
    AWVALID = 1'b0;
    check("after_rst_mem_we", mem_we, 1);
    BREADY = 1'b1;
    tick();
    check("after_rst_bvalid", {BVALID, BRESP}, 3'b100);
    tick();
    BREADY = 1'b0;

    // Random phase against the rule-level model
    for (int t = 0; t < 40; t++) begin
      logic [AW-1:0] a;
      logic          ok;
      case ($urandom_range(0, 3))
        0:       a = AW'($urandom_range(0, DEPTH - 1));
        1:       a = AW'(DEPTH - 1 + $urandom_range(0, 1));
        2:       a = $urandom;
        default: a = AW'(DEPTH + $urandom_range(0, 15));
      endcase
      ok = (a < AW'(DEPTH));
      do_write(a, $urandom, SW'($urandom_range(0, 15)), $urandom_range(0, 3),
               $urandom_range(0, 3), $urandom_range(0, 3), ok, ok ? 2'b00 : 2'b10);
    end

    tick();
    tick();
    check("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi4_lite_slave_write_ctrl.md
# axi4_lite_slave_write_ctrl

Slave-side responder for the AXI4-Lite write path: accepts one write address (AW) and one write data (W) beat in any order, commits them to a word-indexed memory through a single-cycle write port, then drives the write response (B) channel until the master accepts it. It sits between the `axi4_lite_if` slave modport signals and the slave's storage array. It is the generating end of the BVALID/BRESP handshake that the master's BREADY logic consumes. One transaction is outstanding at a time.

## Interface
- Addr_Width, 32, address width (from `axi4_lite_Defs`)
- Data_Width, 32, data width; must be a multiple of 8
- MEM_DEPTH, 4096, number of memory words; valid addresses are 0..MEM_DEPTH-1
- ACLK  in  1  system clock, all logic on rising edge
- ARESET  in  1  asynchronous, active-high reset
- AWADDR  in  Addr_Width  write address (word index)
- AWVALID  in  1  address valid
- AWREADY  out  1  address accepted
- WDATA  in  Data_Width  write data
- WSTRB  in  Data_Width/8  byte lane enables
- WVALID  in  1  data valid
- WREADY  out  1  data accepted
- BRESP  out  2  response: 2'b00 OKAY, 2'b10 SLVERR
- BVALID  out  1  response valid
- BREADY  in  1  master ready for response
- mem_we  out  1  single-cycle memory write strobe
- mem_addr  out  Addr_Width  memory word index
- mem_wdata  out  Data_Width  memory write data
- mem_wstrb  out  Data_Width/8  memory byte enables

## Operation
- States: IDLE, HAVE_ADDR, HAVE_DATA, WRITE, RESP. Reset state IDLE.
- IDLE: AWREADY=1, WREADY=1. Both handshakes in the same edge -> WRITE. AW only -> HAVE_ADDR. W only -> HAVE_DATA.
- HAVE_ADDR: AWREADY=0, WREADY=1. W handshake -> WRITE.
- HAVE_DATA: AWREADY=1, WREADY=0. AW handshake -> WRITE.
- Handshake = VALID & READY sampled at a rising ACLK edge. AWADDR is captured on the AW handshake. WDATA and WSTRB are captured on the W handshake.
- WRITE lasts one cycle.
  - Captured address < MEM_DEPTH: mem_we=1, with mem_addr, mem_wdata and mem_wstrb driven from the capture registers. Response is OKAY.
  - Captured address >= MEM_DEPTH: mem_we=0 and response is SLVERR.
  - WSTRB=0 with a valid address: mem_we=1 with mem_wstrb=0, response OKAY.
  - Next state is RESP.
- RESP: BVALID=1, and BRESP holds the decided response. AWREADY=0 and WREADY=0.
  - BVALID & BREADY at an edge -> IDLE.
  - BVALID and BRESP must stay stable until that edge, regardless of BREADY toggling.
- BREADY already high on BVALID's first cycle completes the response in that one cycle.
- Address comparison is unsigned, full Addr_Width. No address wrap or truncation.
- AWREADY, WREADY, BVALID and BRESP are registered outputs, decoded from the next state. mem_* outputs are decoded from the current state (WRITE).

## Timing
- Reset (ARESET=1, asynchronous): AWREADY=0, WREADY=0, BVALID=0, BRESP=2'b00, mem_we=0, mem_addr=0, mem_wdata=0, mem_wstrb=0. Capture registers are cleared.
- First rising edge with ARESET=0: AWREADY=1 and WREADY=1.
- Latency, last handshake at edge N:
  - mem_we high for the cycle between edges N and N+1.
  - BVALID high after edge N+1.
  - AWREADY and WREADY return high the cycle after the B handshake edge.
- Minimum transaction period with BREADY held high: 3 cycles (accept, write, respond).
- ARESET asserted in any state: immediate return to IDLE outputs-as-reset. A pending capture or a pending response is discarded; no mem_we is issued for it.
- AWVALID/WVALID asserted while the matching READY is 0: ignored, nothing captured. The master must hold VALID (AXI rule).

## Test plan
- Simultaneous AW/W: AWADDR=32'ha9b, WDATA=32'h1a2b3c4d, WSTRB=4'hf, BREADY=1 -> mem_we pulse with mem_addr=0xa9b, data 1a2b3c4d; BVALID for 1 cycle, BRESP=00; READYs high again on the following cycle.
- W before AW: W (WDATA=32'hdeadbeef, WSTRB=4'h3) at edge 1, AW (addr 0x10) at edge 4 -> WREADY=0 from edge 1, one mem_we after edge 4 with mem_wstrb=4'h3, BRESP=00.
- Out of range: AWADDR=MEM_DEPTH (0x1000) -> no mem_we, BVALID with BRESP=2'b10.
- Backpressure: BREADY=0 for 5 cycles -> BVALID=1 and BRESP constant throughout, AWREADY=WREADY=0; raise BREADY -> BVALID low next edge.
- Reset mid-response: assert ARESET while BVALID=1 -> BVALID, AWREADY and WREADY go 0 without waiting for an edge, no extra mem_we; after release, a new write at 0x20 completes normally.
- Reset and stability checks: a bench with assertions confirms BVALID=0 whenever ARESET=1, no X on BVALID or READY outputs after reset, and BVALID held until BREADY.
